// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// state codes, opcodes and datapath mux/ALU selects.
package mips_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS datapath with
// optional extension opcodes and memory handshake.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS   = 1,
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned TRAP_HALT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic       branch,
  output logic       branch_ne,
  output logic       pcwrite,
  output logic       memreq,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t state;
  state_t next;
  state_t dec_next;
  logic   ready;
  logic   ext_en;
  logic   is_bne;

  assign ready   = (MEM_WAIT == 0) || mem_ready;
  assign ext_en  = (EXT_OPS != 0);
  assign is_bne  = ext_en && (op == OP_BNE);
  assign state_o = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next;
  end

  always_comb begin
    dec_next = S_TRAP;
    unique case (1'b1)
      op == OP_RTYPE:
        dec_next = S_EXEC;
      op == OP_LW,
      op == OP_SW:
        dec_next = S_MEMADR;
      op == OP_BEQ,
      is_bne:
        dec_next = S_BRANCH;
      op == OP_ADDI,
      ext_en && (op == OP_ANDI),
      ext_en && (op == OP_ORI),
      ext_en && (op == OP_SLTI):
        dec_next = S_IMMEX;
      op == OP_J:
        dec_next = S_JUMP;
      default: ;
    endcase
  end

  always_comb begin
    next = S_TRAP;
    case (state)
      S_FETCH:  next = ready ? S_DECODE : S_FETCH;
      S_DECODE: next = dec_next;
      S_MEMADR: next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next = S_ALUWB;
      S_IMMEX:  next = S_IMMWB;
      S_MEMWB,
      S_ALUWB,
      S_IMMWB,
      S_BRANCH,
      S_JUMP:   next = S_FETCH;
      S_TRAP:   next = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
      default:  next = S_TRAP;
    endcase
  end

  always_comb begin
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    alusrca   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    pcwrite   = 1'b0;
    memreq    = 1'b0;
    alusrcb   = SRCB_REG;
    pcsrc     = PC_INC;
    aluop     = ALU_ADD;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        // IR/PC commit only on the cycle the fetch completes
        memreq  = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = ready;
        pcwrite = ready;
      end
      S_DECODE: alusrcb = SRCB_BROFF;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        memreq = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memreq   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        aluop     = ALU_SUB;
        pcsrc     = PC_BR;
        branch    = !is_bne;
        branch_ne = is_bne;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = imm_aluop(op);
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = PC_JMP;
        pcwrite = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 SHALL have parameter EXT_OPS, default 1, which enables the ANDI, ORI, SLTI and BNE opcodes.
REQ-002 SHALL have parameter MEM_WAIT, default 0; when it is 1, memory states wait on mem_ready.
REQ-003 SHALL have parameter TRAP_HALT, default 1; when it is 1, an illegal opcode halts the FSM in TRAP, and when it is 0, TRAP returns to FETCH.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  opcode from the instruction register; stable from DECODE until the next FETCH
- mem_ready  in  1  memory completion; ignored when MEM_WAIT=0
- iord, irwrite, memwrite, memtoreg, regwrite, regdst, alusrca  out  1 each  datapath controls
- branch  out  1  conditional PC write when the ALU result is zero
- branch_ne  out  1  conditional PC write when the ALU result is non-zero
- pcwrite  out  1  unconditional PC write
- memreq  out  1  memory access active
- alusrcb, pcsrc  out  2 each  datapath mux selects
- aluop  out  3  ALU operation class
- illegal  out  1  high while in TRAP
- state_o  out  4  current state, for debug

Function
REQ-005 SHALL be a Moore FSM: every output is decoded from the 4-bit state register only, except the mem_ready qualification in REQ-009.
REQ-006 SHALL deassert every output not listed for a state (value 0) in that state.
REQ-007 SHALL implement these states, codes and outputs:
- FETCH=0: memreq=1, alusrcb=01, aluop=000, irwrite=1, pcwrite=1
- DECODE=1: alusrcb=11, aluop=000
- MEMADR=2: alusrca=1, alusrcb=10, aluop=000
- MEMRD=3: iord=1, memreq=1
- MEMWB=4: memtoreg=1, regwrite=1
- MEMWR=5: iord=1, memreq=1, memwrite=1
- EXEC=6: alusrca=1, aluop=010
- ALUWB=7: regdst=1, regwrite=1
- BRANCH=8: alusrca=1, aluop=001, pcsrc=01, branch=1 for BEQ or branch_ne=1 for BNE
- IMMEX=9: alusrca=1, alusrcb=10, aluop=000 (ADDI), 011 (ANDI), 100 (ORI) or 101 (SLTI)
- IMMWB=10: regwrite=1
- JUMP=11: pcsrc=10, pcwrite=1
- TRAP=12: illegal=1
REQ-008 SHALL use these transitions:
- FETCH->DECODE.
- From DECODE by op: 000000->EXEC; 100011/101011->MEMADR; 000100->BRANCH; 001000->IMMEX; 000010->JUMP.
- When EXT_OPS=1, also from DECODE: 000101 (BNE)->BRANCH; 001100 (ANDI), 001101 (ORI), 001010 (SLTI)->IMMEX.
- Any other op, including extension ops when EXT_OPS=0, goes DECODE->TRAP.
- MEMADR->MEMRD for LW and MEMADR->MEMWR for SW.
- MEMRD->MEMWB.
- EXEC->ALUWB; IMMEX->IMMWB.
- MEMWB, MEMWR, ALUWB, IMMWB, BRANCH and JUMP each go to FETCH.
- TRAP stays in TRAP when TRAP_HALT=1 and goes to FETCH when TRAP_HALT=0.
- Unused codes 13-15 go to TRAP.
REQ-009 SHALL, when MEM_WAIT=1, hold FETCH, MEMRD and MEMWR while mem_ready=0, with the following rules:
- In FETCH, irwrite and pcwrite are asserted only in the cycle where mem_ready=1.
- memreq and memwrite stay asserted for every cycle of the hold.
REQ-010 SHALL give these cycle counts from FETCH entry with no waits: LW 5; SW, R-type, ADDI and the extension immediates 4; BEQ, BNE and J 3.
REQ-011 SHALL extend each memory state by exactly N cycles when mem_ready is low for N consecutive cycles in that state.

Reset
REQ-012 SHALL force the state to FETCH asynchronously while reset_n=0, and SHALL release it on the first clk rising edge after reset_n rises.
REQ-013 SHALL drive the FETCH output values during reset, including the case where reset aborts a sequence mid-instruction (for example in MEMWR, memwrite drops immediately).

Structure
REQ-014 SHALL take the following from shared package mips_ctrl_pkg: the state enum, the opcode constants, the aluop, alusrcb and pcsrc encodings, and the state_t width.
REQ-015 SHALL place the next-state logic and the output decode in a single module with no sub-modules; one always_ff holds the state register and combinational blocks produce next state and outputs.

Verification
REQ-016 SHALL have the bench cover these directed scenarios:
- Reset pulse mid-MEMWR -> memwrite falls with reset_n without waiting for clk; after release, state_o=0 and FETCH controls are present.
- op=100011, MEM_WAIT=0 -> state_o sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
- op=000101: with EXT_OPS=1 -> 0,1,8,0 with branch_ne=1, branch=0; with EXT_OPS=0 -> 0,1,12 and illegal=1 held for 10 cycles.
- MEM_WAIT=1, op=101011, mem_ready low for 3 cycles in MEMWR -> MEMWR lasts 4 cycles with memwrite=1 in all of them, then FETCH.
- MEM_WAIT=1, mem_ready low for 2 cycles in FETCH -> irwrite and pcwrite are high in exactly 1 cycle (the 3rd), then DECODE.
- op=001101 -> 0,1,9,10,0 with aluop=100 in IMMEX; op=111111 with TRAP_HALT=0 -> 0,1,12,0.
